// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]            addr;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with async reset, occupancy count and a flush that empties it in one cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Flush,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Pop,
  output logic [WIDTH-1:0] o_Data,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Full,
  output logic             o_Empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_Full  = (r_count == CNT_W'(DEPTH));
  assign o_Empty = (r_count == '0);
  assign o_Count = r_count;
  assign o_Data  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_Push & (~o_Full | i_Pop) & ~i_Flush;
  assign w_do_pop  = i_Pop & ~o_Empty & ~i_Flush;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_Data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: credit-limited pipelined instruction reads, redirect handling with stale-response
// squashing, and an instruction buffer feeding decode.
`ifndef RESET_VECTOR_ADDRESS
`define RESET_VECTOR_ADDRESS 32'h0000_0000
`endif

module fetch_sequencer import fetch_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR    = `RESET_VECTOR_ADDRESS,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          BUFFER_DEPTH    = 2,
  localparam int         OW              = $clog2(MAX_OUTSTANDING + 1),
  localparam int         BW              = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Redirect,
  input  logic [31:0]            i_RedirectAddress,
  output logic                   o_MemReqValid,
  input  logic                   i_MemReqReady,
  output logic [31:0]            o_MemReqAddress,
  input  logic                   i_MemRespValid,
  input  logic [INSTR_WIDTH-1:0] i_MemRespData,
  output logic                   o_InstrValid,
  input  logic                   i_InstrReady,
  output logic [INSTR_WIDTH-1:0] o_Instr,
  output logic [31:0]            o_InstrAddress,
  output logic                   o_FetchFault,
  output logic [1:0]             o_DebugState,
  output logic [OW-1:0]          o_DebugStale
);

  localparam logic [1:0] ST_BOOT  = BOOT;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_FAULT = FAULT;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [31:0]        r_pc;
  logic [OW-1:0]      r_outstanding;
  logic [OW-1:0]      r_stale;
  logic [OW-1:0]      w_out_next;
  logic [31:0]        w_credit_used;
  logic               w_req_fire;
  logic               w_resp_keep;
  logic               w_instr_pop;
  logic               w_target_ok;
  logic [31:0]        w_aq_head;
  logic [OW-1:0]      w_aq_count;
  logic               w_aq_full;
  logic               w_aq_empty;
  fetch_entry_t       w_buf_in;
  fetch_entry_t       w_buf_head;
  logic [BW-1:0]      w_buf_count;
  logic               w_buf_full;
  logic               w_buf_empty;
  logic               w_unused;

  // Every channel transfers on a cycle where valid & ready are both high; valid never waits on ready.
  // Requests are issued only while a buffer slot is reserved for each live (non-stale) response.
  assign w_credit_used = 32'(r_outstanding) - 32'(r_stale) + 32'(w_buf_count);
  assign o_MemReqValid = (r_state == ST_FETCH)
                       && (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                       && (w_credit_used < 32'(BUFFER_DEPTH));
  assign o_MemReqAddress = r_pc;
  assign w_req_fire      = o_MemReqValid & i_MemReqReady;
  assign w_target_ok     = is_aligned(i_RedirectAddress);
  assign w_resp_keep     = i_MemRespValid & (r_stale == '0) & ~i_Redirect;
  assign w_instr_pop     = o_InstrValid & i_InstrReady & ~i_Redirect;

  assign w_buf_in.addr  = w_aq_head;
  assign w_buf_in.instr = i_MemRespData;

  assign o_InstrValid   = ~w_buf_empty;
  assign o_Instr        = w_buf_head.instr;
  assign o_InstrAddress = w_buf_head.addr;
  assign o_FetchFault   = (r_state == ST_FAULT);
  assign o_DebugState   = r_state;
  assign o_DebugStale   = r_stale;
  assign w_unused       = ^{w_aq_count, w_aq_full, w_aq_empty, w_buf_full};

  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_addr_q (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Flush (1'b0),
    .i_Push  (w_req_fire),
    .i_Data  (r_pc),
    .i_Pop   (i_MemRespValid),
    .o_Data  (w_aq_head),
    .o_Count (w_aq_count),
    .o_Full  (w_aq_full),
    .o_Empty (w_aq_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUFFER_DEPTH)) u_instr_buf (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Flush (i_Redirect),
    .i_Push  (w_resp_keep),
    .i_Data  (w_buf_in),
    .i_Pop   (w_instr_pop),
    .o_Data  (w_buf_head),
    .o_Count (w_buf_count),
    .o_Full  (w_buf_full),
    .o_Empty (w_buf_empty)
  );

  always_comb begin
    w_out_next = r_outstanding;
    if (w_req_fire && !i_MemRespValid)      w_out_next = r_outstanding + OW'(1);
    else if (!w_req_fire && i_MemRespValid) w_out_next = r_outstanding - OW'(1);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT:  w_state_next = (i_Redirect && !w_target_ok) ? ST_FAULT : ST_FETCH;
      ST_FETCH: if (i_Redirect && !w_target_ok) w_state_next = ST_FAULT;
      ST_FAULT: if (i_Redirect && w_target_ok) w_state_next = ST_FETCH;
      default:  w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      if (i_Redirect) begin
        if (w_target_ok) r_pc <= i_RedirectAddress;
      end else if (w_req_fire) begin
        r_pc <= r_pc + PC_STEP;
      end
      // The response arriving with a redirect is dropped directly, so it is not counted as stale.
      if (i_Redirect)                             r_stale <= w_out_next;
      else if (i_MemRespValid && r_stale != '0)   r_stale <= r_stale - OW'(1);
    end
  end

  a_out_bound: assert property (@(posedge i_Clock) disable iff (i_Reset)
    32'(r_outstanding) <= 32'(MAX_OUTSTANDING));
  a_stale_bound: assert property (@(posedge i_Clock) disable iff (i_Reset)
    r_stale <= r_outstanding);
  a_no_orphan_resp: assert property (@(posedge i_Clock) disable iff (i_Reset)
    i_MemRespValid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed cycle table for fetch_sequencer plus hand sequences for PC wrap and mid-burst reset.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] raddr = '0;
  logic        req_v;
  logic        req_rdy = 1'b0;
  logic [31:0] req_a;
  logic        rsp_v = 1'b0;
  logic [31:0] rsp_d = '0;
  logic        ins_v;
  logic        ins_rdy = 1'b0;
  logic [31:0] ins;
  logic [31:0] ins_a;
  logic        fault;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_stale;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  fetch_sequencer #(.RESET_VECTOR(32'h0), .MAX_OUTSTANDING(2), .BUFFER_DEPTH(2)) dut (
    .i_Clock           (clk),
    .i_Reset           (rst),
    .i_Redirect        (redir),
    .i_RedirectAddress (raddr),
    .o_MemReqValid     (req_v),
    .i_MemReqReady     (req_rdy),
    .o_MemReqAddress   (req_a),
    .i_MemRespValid    (rsp_v),
    .i_MemRespData     (rsp_d),
    .o_InstrValid      (ins_v),
    .i_InstrReady      (ins_rdy),
    .o_Instr           (ins),
    .o_InstrAddress    (ins_a),
    .o_FetchFault      (fault),
    .o_DebugState      (dbg_state),
    .o_DebugStale      (dbg_stale)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every word decode accepts must match the head of the expected stream.
  always @(negedge clk) begin
    if (!rst && ins_v && ins_rdy && !redir) begin
      if (exp_q.size() == 0) check32("sb_unexpected_word", ins, 32'hFFFF_FFFF);
      else check32("sb_word", ins, exp_q.pop_front());
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        redir;
    logic [31:0] raddr;
    logic        req_rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        ins_rdy;
    logic        exp_req_v;
    logic [31:0] exp_req_a;
    logic        exp_ins_v;
    logic [31:0] exp_ins;
    logic [31:0] exp_ins_a;
    logic        exp_fault;
    int          exp_stale;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic rd, input logic [31:0] ra, input logic qr,
                     input logic rv, input logic [31:0] rdat, input logic ir,
                     input logic ev, input logic [31:0] ea, input logic iv,
                     input logic [31:0] ei, input logic [31:0] eia, input logic ef, input int es);
    vec_t v;
    v.name = n; v.redir = rd; v.raddr = ra; v.req_rdy = qr; v.rsp_v = rv; v.rsp_d = rdat;
    v.ins_rdy = ir; v.exp_req_v = ev; v.exp_req_a = ea; v.exp_ins_v = iv; v.exp_ins = ei;
    v.exp_ins_a = eia; v.exp_fault = ef; v.exp_stale = es;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    redir = v.redir; raddr = v.raddr; req_rdy = v.req_rdy;
    rsp_v = v.rsp_v; rsp_d = v.rsp_d; ins_rdy = v.ins_rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req_v"}, 32'(req_v), 32'd0);
    check32({tag, "_req_a"}, req_a, 32'h0);
    check32({tag, "_ins_v"}, 32'(ins_v), 32'd0);
    check32({tag, "_fault"}, 32'(fault), 32'd0);
    check32({tag, "_state"}, 32'(dbg_state), 32'(BOOT));
    check32({tag, "_stale"}, 32'(dbg_stale), 32'd0);
  endtask

  initial begin
    // Response data is address ^ 0xDEAD0000 throughout.
    //   name   rd ra            qr rv rsp_d         ir | ev ea            iv ins           ins_a        f  stale
    add("boot",  0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,       0, 0);
    add("req0",  0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        32'h0,       0, -1);
    add("req4",  0, 32'h0,        1, 1, 32'hDEAD0000, 1,   1, 32'h4,        0, 32'h0,        32'h0,       0, -1);
    add("ins0",  0, 32'h0,        1, 1, 32'hDEAD0004, 1,   0, 32'h8,        1, 32'hDEAD0000, 32'h0,       0, -1);
    add("ins4",  0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h8,        1, 32'hDEAD0004, 32'h4,       0, -1);
    add("stallA",0, 32'h0,        1, 1, 32'hDEAD0008, 0,   1, 32'hC,        0, 32'h0,        32'h0,       0, -1);
    add("stallB",0, 32'h0,        1, 1, 32'hDEAD000C, 0,   0, 32'h10,       1, 32'hDEAD0008, 32'h8,       0, -1);
    add("full",  0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h10,       1, 32'hDEAD0008, 32'h8,       0, -1);
    add("rel8",  0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h10,       1, 32'hDEAD0008, 32'h8,       0, -1);
    add("relC",  0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h10,       1, 32'hDEAD000C, 32'hC,       0, -1);
    add("req14", 0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h14,       0, 32'h0,        32'h0,       0, -1);
    add("rd100", 1, 32'h100,      1, 0, 32'h0,        1,   0, 32'h18,       0, 32'h0,        32'h0,       0, 0);
    add("drop1", 0, 32'h0,        1, 1, 32'hDEAD0010, 1,   0, 32'h100,      0, 32'h0,        32'h0,       0, 2);
    add("drop2", 0, 32'h0,        1, 1, 32'hDEAD0014, 1,   1, 32'h100,      0, 32'h0,        32'h0,       0, 1);
    add("rsp100",0, 32'h0,        1, 1, 32'hDEAD0100, 1,   1, 32'h104,      0, 32'h0,        32'h0,       0, 0);
    add("ins100",0, 32'h0,        1, 0, 32'h0,        1,   0, 32'h108,      1, 32'hDEAD0100, 32'h100,     0, -1);
    add("rdSame",1, 32'h200,      1, 1, 32'hDEAD0104, 1,   1, 32'h108,      0, 32'h0,        32'h0,       0, 0);
    add("rdMis", 1, 32'h102,      0, 0, 32'h0,        1,   1, 32'h200,      0, 32'h0,        32'h0,       0, 1);
    add("fault", 0, 32'h0,        1, 1, 32'hDEAD0108, 1,   0, 32'h200,      0, 32'h0,        32'h0,       1, 1);
    add("rdFix", 1, 32'h200,      1, 0, 32'h0,        1,   0, 32'h200,      0, 32'h0,        32'h0,       1, 0);
    add("req200",0, 32'h0,        1, 0, 32'h0,        1,   1, 32'h200,      0, 32'h0,        32'h0,       0, 0);
    add("rsp200",0, 32'h0,        0, 1, 32'hDEAD0200, 1,   1, 32'h204,      0, 32'h0,        32'h0,       0, -1);
    add("ins200",0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h204,      1, 32'hDEAD0200, 32'h200,     0, -1);
    add("idle",  0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h204,      0, 32'h0,        32'h0,       0, 0);

    exp_q = '{32'hDEAD0000, 32'hDEAD0004, 32'hDEAD0008, 32'hDEAD000C, 32'hDEAD0100, 32'hDEAD0200};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check32({vecs[i].name, "_req_v"}, 32'(req_v), 32'(vecs[i].exp_req_v));
      check32({vecs[i].name, "_req_a"}, req_a, vecs[i].exp_req_a);
      check32({vecs[i].name, "_ins_v"}, 32'(ins_v), 32'(vecs[i].exp_ins_v));
      check32({vecs[i].name, "_fault"}, 32'(fault), 32'(vecs[i].exp_fault));
      if (vecs[i].exp_ins_v) begin
        check32({vecs[i].name, "_ins"}, ins, vecs[i].exp_ins);
        check32({vecs[i].name, "_ins_a"}, ins_a, vecs[i].exp_ins_a);
      end
      if (vecs[i].exp_stale >= 0)
        check32({vecs[i].name, "_stale"}, 32'(dbg_stale), 32'(vecs[i].exp_stale));
      step();
    end

    // PC wrap at the top of the address space.
    redir = 1'b1; raddr = 32'hFFFF_FFFC; req_rdy = 1'b0; rsp_v = 1'b0; ins_rdy = 1'b0;
    step();
    redir = 1'b0; req_rdy = 1'b1;
    #1;
    check32("wrap_req_v", 32'(req_v), 32'd1);
    check32("wrap_req_a_top", req_a, 32'hFFFF_FFFC);
    step();
    rsp_v = 1'b1; rsp_d = 32'h2152_FFFC;
    #1;
    check32("wrap_req_a_zero", req_a, 32'h0);
    step();
    rsp_v = 1'b0; req_rdy = 1'b0;
    #1;
    check32("wrap_ins_v", 32'(ins_v), 32'd1);
    check32("wrap_ins", ins, 32'h2152_FFFC);
    check32("wrap_ins_a", ins_a, 32'hFFFF_FFFC);
    check32("wrap_req_a_next", req_a, 32'h4);

    // Reset mid-burst: outputs return to reset values without waiting for a clock edge.
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    req_rdy = 1'b1;
    step();
    check32("post_rst_req_v", 32'(req_v), 32'd1);
    check32("post_rst_req_a", req_a, 32'h0);
    check32("post_rst_state", 32'(dbg_state), 32'(FETCH));
    req_rdy = 1'b0;
    step();

    check32("sb_all_words_seen", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
